fan_speed_controller: RTL and testbench

Fan speed mode FSM and PWM motor driver for the fan board: the enable/expiry counterpart of the off-timer. A one-cycle button pulse cycles the fan OFF → LOW → MID → HIGH → OFF. While the fan is running, the block asserts `timer_en` to arm the off-timer, and it returns to OFF when the timer reports expiry on `timer_done`. The motor output is a soft-started PWM whose duty ramps toward the duty set for the selected mode.

---
 rtl/fan_speed_controller.sv | 120 ++++++++++++
 tb/tb_fan_speed_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_speed_controller.sv
// fan_speed_controller
// Fan mode FSM (OFF -> LOW -> MID -> HIGH -> OFF) driven by a speed button,
// with an off-timer handshake and a soft-start PWM motor output. The applied
// duty ramps up toward the mode target once per PWM period and drops at once.

module fan_speed_controller #(
    parameter int PWM_PRESCALE = 125,
    parameter int PWM_STEPS    = 100,
    parameter int DUTY_LOW     = 30,
    parameter int DUTY_MID     = 60,
    parameter int DUTY_HIGH    = 90,
    parameter int RAMP_STEP    = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_speed_p,
    input  logic       timer_done,
    output logic       fan_pwm,
    output logic       timer_en,
    output logic [3:0] speed_led,
    output logic [6:0] duty_cur
);

    localparam logic [3:0] S_OFF  = 4'b0001;
    localparam logic [3:0] S_LOW  = 4'b0010;
    localparam logic [3:0] S_MID  = 4'b0100;
    localparam logic [3:0] S_HIGH = 4'b1000;

    localparam int PRE_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int STEP_W = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;

    // Targets are clamped so the applied duty can never exceed a full period.
    localparam int T_LOW  = (DUTY_LOW  > PWM_STEPS) ? PWM_STEPS : DUTY_LOW;
    localparam int T_MID  = (DUTY_MID  > PWM_STEPS) ? PWM_STEPS : DUTY_MID;
    localparam int T_HIGH = (DUTY_HIGH > PWM_STEPS) ? PWM_STEPS : DUTY_HIGH;

    logic [3:0]        state;
    logic [3:0]        state_next;
    logic [PRE_W-1:0]  pre_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic              pre_wrap;
    logic              period_end;
    logic [6:0]        duty_target;
    logic [7:0]        ramp_sum;

    // Next mode: expiry of the off-timer beats a simultaneous button press.
    always_comb begin
        state_next = state;
        if (timer_done && !state[0]) begin
            state_next = S_OFF;
        end else if (btn_speed_p) begin
            state_next = {state[2:0], state[3]};
        end
    end

    // Mode register, one-hot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_OFF;
        end else begin
            state <= state_next;
        end
    end

    assign speed_led = state;
    assign timer_en  = ~state[0];

    // Duty the current mode is heading toward.
    always_comb begin
        duty_target = 7'd0;
        case (state)
            S_LOW:   duty_target = 7'(T_LOW);
            S_MID:   duty_target = 7'(T_MID);
            S_HIGH:  duty_target = 7'(T_HIGH);
            default: duty_target = 7'd0;
        endcase
    end

    assign pre_wrap   = (pre_cnt == PRE_W'(PWM_PRESCALE - 1));
    assign period_end = pre_wrap && (step_cnt == STEP_W'(PWM_STEPS - 1));
    assign ramp_sum   = {1'b0, duty_cur} + 8'(RAMP_STEP);

    // Prescaler and step counters free-run in every mode, including OFF.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt  <= '0;
            step_cnt <= '0;
        end else if (pre_wrap) begin
            pre_cnt  <= '0;
            step_cnt <= period_end ? '0 : step_cnt + STEP_W'(1);
        end else begin
            pre_cnt  <= pre_cnt + PRE_W'(1);
        end
    end

    // Applied duty: held at zero while OFF, otherwise ramps up or snaps down once per period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_cur <= 7'd0;
        end else if (state[0]) begin
            duty_cur <= 7'd0;
        end else if (period_end) begin
            if (duty_cur < duty_target) begin
                duty_cur <= (ramp_sum >= {1'b0, duty_target}) ? duty_target : ramp_sum[6:0];
            end else begin
                duty_cur <= duty_target;
            end
        end
    end

    // Registered PWM compare so the motor pin never sees combinational glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fan_pwm <= 1'b0;
        end else begin
            fan_pwm <= (8'(step_cnt) < {1'b0, duty_cur});
        end
    end

endmodule

// File: tb/tb_fan_speed_controller.sv
// tb_fan_speed_controller
// Self-checking bench: mode-sequence table, hand-written ramp/expiry/reset
// sequences, and a randomized run compared against a period-level model.

module tb_fan_speed_controller;

    localparam int PRE   = 1;
    localparam int STEPS = 100;
    localparam int DL    = 30;
    localparam int DM    = 60;
    localparam int DH    = 90;
    localparam int RAMP  = 5;

    logic       clk;
    logic       reset_n;
    logic       btn_speed_p;
    logic       timer_done;
    logic       fan_pwm;
    logic       timer_en;
    logic [3:0] speed_led;
    logic [6:0] duty_cur;

    int checks;
    int errors;
    bit bg_en;

    fan_speed_controller #(
        .PWM_PRESCALE(PRE),
        .PWM_STEPS   (STEPS),
        .DUTY_LOW    (DL),
        .DUTY_MID    (DM),
        .DUTY_HIGH   (DH),
        .RAMP_STEP   (RAMP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_speed_p(btn_speed_p),
        .timer_done (timer_done),
        .fan_pwm    (fan_pwm),
        .timer_en   (timer_en),
        .speed_led  (speed_led),
        .duty_cur   (duty_cur)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: mode number 0..3 and elapsed clocks since reset.
    typedef struct {
        int mode;
        int duty;
        bit pwm;
        int t;
    } model_t;

    model_t m;

    function automatic int duty_of(int mode);
        case (mode)
            1:       return DL;
            2:       return DM;
            3:       return DH;
            default: return 0;
        endcase
    endfunction

    function automatic model_t model_next(model_t cur, logic btn, logic done);
        model_t n = cur;
        int target;
        n.pwm = (((cur.t / PRE) % STEPS) < cur.duty);
        if (cur.mode == 0) begin
            n.duty = 0;
        end else if ((cur.t % (PRE * STEPS)) == (PRE * STEPS - 1)) begin
            target = duty_of(cur.mode);
            if (cur.duty < target) n.duty = (cur.duty + RAMP < target) ? cur.duty + RAMP : target;
            else                   n.duty = target;
        end
        if (done && cur.mode != 0) n.mode = 0;
        else if (btn)              n.mode = (cur.mode + 1) % 4;
        n.t = cur.t + 1;
        return n;
    endfunction

    // Advance the model on the same edges the DUT sees.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '{mode: 0, duty: 0, pwm: 1'b0, t: 0};
        else          m <= model_next(m, btn_speed_p, timer_done);
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison of every output against the model, mid-cycle.
    always @(negedge clk) begin
        if (reset_n && bg_en) begin
            checkOutput("model_led",  {4'b0, speed_led}, 8'(4'b0001 << m.mode));
            checkOutput("model_ten",  {7'b0, timer_en},  8'(m.mode != 0));
            checkOutput("model_duty", {1'b0, duty_cur},  8'(m.duty));
            checkOutput("model_pwm",  {7'b0, fan_pwm},   8'(m.pwm));
        end
    end

    // One-cycle pulse driven from a falling edge; returns on the next falling edge.
    task automatic applyStimulus(input logic btn, input logic done);
        @(negedge clk);
        btn_speed_p = btn;
        timer_done  = done;
        @(negedge clk);
        btn_speed_p = 1'b0;
        timer_done  = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_led",  {4'b0, speed_led}, 8'h01);
        checkOutput("rst_ten",  {7'b0, timer_en},  8'h00);
        checkOutput("rst_duty", {1'b0, duty_cur},  8'h00);
        checkOutput("rst_pwm",  {7'b0, fan_pwm},   8'h00);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic waitDuty(input int value, input int budget);
        int n = 0;
        while (duty_cur != 7'(value) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_duty", {1'b0, duty_cur}, 8'(value));
    endtask

    typedef struct {
        logic       btn;
        logic       done;
        logic [3:0] exp_led;
        logic       exp_ten;
        int         gap;
    } vec_t;

    vec_t vecs[11];
    int   ramp_exp[6];

    // Watchdog so the bench always ends.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nchg;
        int hi;
        logic [6:0] prev;

        checks      = 0;
        errors      = 0;
        bg_en       = 1'b1;
        reset_n     = 1'b1;
        btn_speed_p = 1'b0;
        timer_done  = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 4'b0010, 1'b1, 9};
        vecs[1]  = '{1'b1, 1'b0, 4'b0100, 1'b1, 9};
        vecs[2]  = '{1'b1, 1'b0, 4'b1000, 1'b1, 9};
        vecs[3]  = '{1'b1, 1'b0, 4'b0001, 1'b0, 9};
        vecs[4]  = '{1'b0, 1'b1, 4'b0001, 1'b0, 3};
        vecs[5]  = '{1'b1, 1'b0, 4'b0010, 1'b1, 3};
        vecs[6]  = '{1'b1, 1'b0, 4'b0100, 1'b1, 3};
        vecs[7]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 3};
        vecs[8]  = '{1'b0, 1'b0, 4'b0001, 1'b0, 3};
        vecs[9]  = '{1'b1, 1'b0, 4'b0010, 1'b1, 3};
        vecs[10] = '{1'b0, 1'b1, 4'b0001, 1'b0, 3};
        ramp_exp = '{5, 10, 15, 20, 25, 30};

        // Mode cycling, expiry in OFF, button/expiry collision.
        doReset();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].btn, vecs[i].done);
            checkOutput($sformatf("tbl_led[%0d]", i), {4'b0, speed_led}, {4'b0, vecs[i].exp_led});
            checkOutput($sformatf("tbl_ten[%0d]", i), {7'b0, timer_en},  {7'b0, vecs[i].exp_ten});
            repeat (vecs[i].gap) @(negedge clk);
        end

        // Soft start in LOW: 5,10,...,30 then steady 30-clock high time.
        doReset();
        applyStimulus(1'b1, 1'b0);
        nchg = 0;
        prev = duty_cur;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (duty_cur != prev) begin
                if (nchg < 6) checkOutput($sformatf("ramp[%0d]", nchg), {1'b0, duty_cur}, 8'(ramp_exp[nchg]));
                nchg++;
                prev = duty_cur;
            end
        end
        checkOutput("ramp_changes", 8'(nchg), 8'd6);
        hi = 0;
        for (int c = 0; c < STEPS; c++) begin
            @(negedge clk);
            if (fan_pwm) hi++;
        end
        checkOutput("pwm_high_clocks", 8'(hi), 8'd30);

        // Expiry from HIGH at full duty.
        doReset();
        repeat (3) applyStimulus(1'b1, 1'b0);
        waitDuty(90, 2500);
        applyStimulus(1'b0, 1'b1);
        checkOutput("exp_led", {4'b0, speed_led}, 8'h01);
        checkOutput("exp_ten", {7'b0, timer_en},  8'h00);
        repeat (2) @(negedge clk);
        checkOutput("exp_duty", {1'b0, duty_cur}, 8'h00);
        checkOutput("exp_pwm",  {7'b0, fan_pwm},  8'h00);

        // Mid-ramp HIGH -> OFF -> LOW, then asynchronous reset while PWM is high.
        doReset();
        repeat (3) applyStimulus(1'b1, 1'b0);
        waitDuty(40, 1500);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("retgt_led",  {4'b0, speed_led}, 8'h02);
        checkOutput("retgt_duty", {1'b0, duty_cur},  8'h00);
        waitDuty(5, 200);
        hi = 0;
        while (!fan_pwm && hi < 200) begin
            @(negedge clk);
            hi++;
        end
        checkOutput("pre_rst_pwm", {7'b0, fan_pwm}, 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_led",  {4'b0, speed_led}, 8'h01);
        checkOutput("async_ten",  {7'b0, timer_en},  8'h00);
        checkOutput("async_duty", {1'b0, duty_cur},  8'h00);
        checkOutput("async_pwm",  {7'b0, fan_pwm},   8'h00);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Randomized button and expiry pulses against the model.
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            btn_speed_p = ($urandom_range(0, 59) == 0);
            timer_done  = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        btn_speed_p = 1'b0;
        timer_done  = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
